// File: rtl/satd_block_ctrl.sv
// ----------------------------------------------------------------------------
// satd_block_ctrl
//   Sequencer for one 8x8 SATD block evaluation. It clears the row-difference
//   stage, fetches ROWS ORG/CUR row pairs from the pixel source, tags every
//   difference row with its index and a last flag, waits out the
//   Hadamard/accumulate pipeline and then pulses done.
//
// Parameters
//   ROWS      rows per block (2 .. 2**ADDR_W)
//   ADDR_W    width of the row address and the row tags
//   PIPE_LAT  cycles from the last diff row valid to the final SATD result (>= 1)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active-low
//   start      start one block, sampled only in IDLE
//   abort      cancel the current block, no done is issued
//   row_valid  source presents the ORG/CUR row row_addr this cycle
//   row_req    row request to the pixel source
//   row_addr   requested row index (0 outside FETCH)
//   diff_ena   difference stage enable
//   diff_clr   difference stage synchronous clear
//   diff_vld   difference outputs hold a valid row (registered)
//   diff_row   index of the row on the difference outputs (registered)
//   diff_last  diff_vld row is the last row of the block (registered)
//   busy       high in every state except IDLE
//   done       one-cycle pulse, block SATD result valid downstream
// ----------------------------------------------------------------------------
module satd_block_ctrl #(
    parameter int ROWS     = 8,
    parameter int ADDR_W   = 3,
    parameter int PIPE_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              row_valid,
    output logic              row_req,
    output logic [ADDR_W-1:0] row_addr,
    output logic              diff_ena,
    output logic              diff_clr,
    output logic              diff_vld,
    output logic [ADDR_W-1:0] diff_row,
    output logic              diff_last,
    output logic              busy,
    output logic              done
);

    localparam int LAT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FETCH = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [ADDR_W-1:0] row_cnt_r;
    logic [ADDR_W-1:0] row_cnt_s;
    logic [LAT_W-1:0]  lat_cnt_r;
    logic [LAT_W-1:0]  lat_cnt_s;
    logic              accept_s;
    logic              last_row_s;
    logic              lat_end_s;

    assign last_row_s = (row_cnt_r == ADDR_W'(ROWS - 1));
    assign lat_end_s  = (lat_cnt_r == LAT_W'(PIPE_LAT - 1));

    // Next-state, counter updates and state-decoded outputs.
    always_comb begin
        state_s   = state_r;
        row_cnt_s = row_cnt_r;
        lat_cnt_s = lat_cnt_r;
        accept_s  = 1'b0;
        row_req   = 1'b0;
        row_addr  = '0;
        diff_ena  = 1'b0;
        diff_clr  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy      = 1'b0;
                row_cnt_s = '0;
                lat_cnt_s = '0;
                // abort wins over a simultaneous start
                if (start && !abort) begin
                    state_s = ST_CLEAR;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                // the difference stage only clears while it is enabled
                diff_clr  = 1'b1;
                diff_ena  = 1'b1;
                row_cnt_s = '0;
                if (abort) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_FETCH: begin
                row_req  = 1'b1;
                row_addr = row_cnt_r;
                diff_ena = row_valid;
                if (abort) begin
                    state_s   = ST_IDLE;
                    row_cnt_s = '0;
                    lat_cnt_s = '0;
                end else if (row_valid) begin
                    accept_s = 1'b1;
                    if (last_row_s) begin
                        // counter parks at 0 instead of running past ROWS-1
                        state_s   = ST_DRAIN;
                        row_cnt_s = '0;
                        lat_cnt_s = '0;
                    end else begin
                        row_cnt_s = row_cnt_r + ADDR_W'(1);
                    end
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_s   = ST_IDLE;
                    lat_cnt_s = '0;
                end else if (lat_end_s) begin
                    state_s   = ST_DONE;
                    lat_cnt_s = '0;
                end else begin
                    lat_cnt_s = lat_cnt_r + LAT_W'(1);
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_s = ST_IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_s   = ST_IDLE;
                row_cnt_s = '0;
                lat_cnt_s = '0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            row_cnt_r <= '0;
            lat_cnt_r <= '0;
        end else begin
            state_r   <= state_s;
            row_cnt_r <= row_cnt_s;
            lat_cnt_r <= lat_cnt_s;
        end
    end

    // Row tags that travel with the difference stage output one cycle after acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            diff_vld  <= 1'b0;
            diff_row  <= '0;
            diff_last <= 1'b0;
        end else if (accept_s) begin
            diff_vld  <= 1'b1;
            diff_row  <= row_cnt_r;
            diff_last <= last_row_s;
        end else begin
            diff_vld  <= 1'b0;
            diff_row  <= diff_row;
            diff_last <= 1'b0;
        end
    end

endmodule

// File: tb/tb_satd_block_ctrl.sv
// ----------------------------------------------------------------------------
// tb_satd_block_ctrl
//   Two instances share one stimulus stream: the default 8-row block and a
//   4-row block with PIPE_LAT=1 and ADDR_W=2 (ROWS = 2**ADDR_W). Each cycle
//   the outputs of both are compared with a transaction-level model of the
//   block (rows fetched so far, pipeline cycles still to wait). Directed
//   scenarios check done timing; a random phase follows.
// ----------------------------------------------------------------------------
module tb_satd_block_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic       row_valid;

    logic       req8, ena8, clr8, vld8, last8, busy8, done8;
    logic [2:0] addr8, drow8;
    logic       req4, ena4, clr4, vld4, last4, busy4, done4;
    logic [1:0] addr4, drow4;

    int n_cmp;
    int n_err;
    int cyc_n;
    int t0;
    int done8_at;
    int done4_at;

    typedef struct {
        bit act;   // a block is in progress
        bit clr;   // first cycle of the block (stage clear)
        int got;   // rows accepted so far
        int wl;    // pipeline cycles left after the last row
        bit vld;
        int row;
        bit last;
    } blk_t;

    blk_t m8;
    blk_t m4;
    blk_t blk_zero;

    satd_block_ctrl #(.ROWS(8), .ADDR_W(3), .PIPE_LAT(4)) dut8 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .row_valid(row_valid),
        .row_req(req8), .row_addr(addr8), .diff_ena(ena8), .diff_clr(clr8),
        .diff_vld(vld8), .diff_row(drow8), .diff_last(last8), .busy(busy8), .done(done8)
    );

    satd_block_ctrl #(.ROWS(4), .ADDR_W(2), .PIPE_LAT(1)) dut4 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .row_valid(row_valid),
        .row_req(req4), .row_addr(addr4), .diff_ena(ena4), .diff_clr(clr4),
        .diff_vld(vld4), .diff_row(drow4), .diff_last(last4), .busy(busy4), .done(done4)
    );

    logic [31:0] obs8;
    logic [31:0] obs4;
    assign obs8 = {9'b0, busy8, done8, req8, ena8, clr8, vld8, last8, 5'b0, addr8, 5'b0, drow8};
    assign obs4 = {9'b0, busy4, done4, req4, ena4, clr4, vld4, last4, 6'b0, addr4, 6'b0, drow4};

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %08h expected %08h", tag, cyc_n, obs, exp);
        end
    endtask

    // Expected outputs of a block with R rows, packed like obs8/obs4.
    function automatic logic [31:0] m_out(blk_t m, int r, bit v);
        bit busy_e, clr_e, req_e, ena_e, done_e;
        logic [7:0] addr_e;
        logic [7:0] row_e;
        busy_e = m.act;
        clr_e  = m.act && m.clr;
        req_e  = m.act && !m.clr && (m.got < r);
        addr_e = req_e ? 8'(m.got) : 8'd0;
        ena_e  = clr_e || (req_e && v);
        done_e = m.act && !m.clr && (m.got == r) && (m.wl == 0);
        row_e  = 8'(m.row);
        return {9'b0, busy_e, done_e, req_e, ena_e, clr_e, m.vld, m.last, addr_e, row_e};
    endfunction

    // Block progress over one clock edge.
    function automatic blk_t m_next(blk_t m, int r, int l, bit s, bit a, bit v);
        blk_t n;
        bit   acc;
        n   = m;
        acc = m.act && !m.clr && (m.got < r) && v && !a;
        n.vld  = acc;
        n.last = acc && (m.got == r - 1);
        if (acc) n.row = m.got;
        if (!m.act) begin
            if (s && !a) begin
                n.act = 1'b1; n.clr = 1'b1; n.got = 0; n.wl = 0;
            end
        end else if (a) begin
            n.act = 1'b0; n.clr = 1'b0; n.got = 0; n.wl = 0;
        end else if (m.clr) begin
            n.clr = 1'b0;
        end else if (m.got < r) begin
            if (v) begin
                n.got = m.got + 1;
                if (n.got == r) n.wl = l;
            end
        end else if (m.wl > 0) begin
            n.wl = m.wl - 1;
        end else begin
            n.act = 1'b0; n.got = 0;
        end
        return n;
    endfunction

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        @(negedge clk);
        if (!rst) begin
            m8 = blk_zero;
            m4 = blk_zero;
        end
        chk("dut8", obs8, m_out(m8, 8, row_valid));
        chk("dut4", obs4, m_out(m4, 4, row_valid));
        if (done8 && done8_at < 0) done8_at = cyc_n - t0;
        if (done4 && done4_at < 0) done4_at = cyc_n - t0;
        @(posedge clk);
        if (!rst) begin
            m8 = blk_zero;
            m4 = blk_zero;
        end else begin
            m8 = m_next(m8, 8, 4, start, abort, row_valid);
            m4 = m_next(m4, 4, 1, start, abort, row_valid);
        end
        #1;
        cyc_n++;
    endtask

    // Directed block: start at offset 0, optional stalls/abort/extra start/reset drop.
    task automatic run_block(input bit stall, input int n, input int abort_at,
                             input int start_again_at, input int rst_at);
        t0       = cyc_n;
        done8_at = -1;
        done4_at = -1;
        for (int k = 0; k < n; k++) begin
            start     = (k == 0) || (k == start_again_at);
            abort     = (k == abort_at);
            row_valid = stall ? (k % 2 == 1) : 1'b1;
            rst       = (k == rst_at) ? 1'b0 : 1'b1;
            cycle();
        end
        start     = 1'b0;
        abort     = 1'b0;
        row_valid = 1'b0;
        rst       = 1'b1;
        repeat (2) cycle();
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        cyc_n     = 0;
        t0        = 0;
        blk_zero  = '{default: 0};
        m8        = blk_zero;
        m4        = blk_zero;
        rst       = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        row_valid = 1'b0;
        repeat (3) cycle();
        rst = 1'b1;
        repeat (2) cycle();

        // plain block, no stalls
        run_block(1'b0, 18, -1, -1, -1);
        chk("nostall_done8_cyc", 32'(done8_at), 32'd14);
        chk("nostall_done4_cyc", 32'(done4_at), 32'd7);

        // reset dropped while fetching row 3
        run_block(1'b0, 18, -1, -1, 5);
        chk("rst_no_done8", 32'(done8_at), 32'hFFFF_FFFF);
        chk("rst_no_done4", 32'(done4_at), 32'hFFFF_FFFF);

        // alternating row_valid stalls
        run_block(1'b1, 26, -1, -1, -1);
        chk("stall_done8_cyc", 32'(done8_at), 32'd22);
        chk("stall_done4_cyc", 32'(done4_at), 32'd11);

        // abort in DRAIN, then a normal block
        run_block(1'b0, 18, 11, -1, -1);
        chk("abort_drain_no_done8", 32'(done8_at), 32'hFFFF_FFFF);
        run_block(1'b0, 18, -1, -1, -1);
        chk("after_abort_done8", 32'(done8_at), 32'd14);

        // start during FETCH ignored; abort with the last acceptance
        run_block(1'b0, 18, 9, 4, -1);
        chk("abort_last_no_done8", 32'(done8_at), 32'hFFFF_FFFF);
        chk("start_in_fetch_done4", 32'(done4_at), 32'd7);

        // start together with abort in IDLE
        run_block(1'b0, 6, 0, -1, -1);
        chk("start_abort_idle8", 32'(done8_at), 32'hFFFF_FFFF);
        chk("start_abort_idle4", 32'(done4_at), 32'hFFFF_FFFF);

        // random traffic
        for (int k = 0; k < 3000; k++) begin
            start     = ($urandom_range(0, 7) == 0);
            abort     = ($urandom_range(0, 59) == 0);
            row_valid = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 399) != 0);
            cycle();
        end
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        repeat (2) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
